// File: rtl/pid_controller_core_if.sv
// Host configuration write bus for pid_controller_core.
//   cfg_we_in   : 1-cycle write strobe into the shadow register file
//   cfg_addr_in : register address
//   cfg_data_in : write data
// master = host-config decode side, slave = controller core.
interface pid_controller_core_if;
  logic        cfg_we_in;
  logic [7:0]  cfg_addr_in;
  logic [15:0] cfg_data_in;

  modport master (output cfg_we_in, cfg_addr_in, cfg_data_in);
  modport slave  (input  cfg_we_in, cfg_addr_in, cfg_data_in);
endinterface

// File: rtl/pid_controller_core.sv
// Single-channel PID lock loop fed by an AD7606-style 8 x 18-bit ADC.
//   clk17_in / rst_n_in     : system clock, async active-low reset
//   cfg_if (slave)          : shadow register writes
//   module_update_in        : shadow -> active copy
//   adc_cstart_in           : start continuous conversions
//   pid_clear_in            : clear integrator and previous error
//   adc_busy_in, adc_data_a_in/b_in : ADC BUSY and serial DOUTA/DOUTB
//   adc_os_out, adc_convst_out, adc_reset_out, adc_sclk_out, adc_n_cs_out : ADC control
//   out_data / out_valid    : clamped controller output and its update strobe
module pid_controller_core #(
  parameter int W_DATA = 18,
  parameter int N_CHAN = 8,
  parameter int W_COEF = 16,
  parameter int W_OUT  = 16
) (
  input  logic               clk17_in,
  input  logic               rst_n_in,
  pid_controller_core_if.slave cfg_if,
  input  logic               module_update_in,
  input  logic               adc_cstart_in,
  input  logic               pid_clear_in,
  input  logic               adc_busy_in,
  input  logic               adc_data_a_in,
  input  logic               adc_data_b_in,
  output logic [2:0]         adc_os_out,
  output logic               adc_convst_out,
  output logic               adc_reset_out,
  output logic               adc_sclk_out,
  output logic               adc_n_cs_out,
  output logic [W_OUT-1:0]   out_data,
  output logic               out_valid
);

  localparam int LINE_W = (N_CHAN / 2) * W_DATA;   // bits per serial line per conversion
  localparam int CNT_W  = $clog2(LINE_W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LINE_W);
  localparam int W_ERR  = W_DATA + 1;
  localparam int STAGES = 3;

  typedef struct packed {
    logic [2:0]        os;
    logic [W_COEF-1:0] sp;
    logic [W_COEF-1:0] kp;
    logic [W_COEF-1:0] ki;
    logic [W_COEF-1:0] kd;
    logic [2:0]        src;
    logic [W_OUT-1:0]  init;
    logic [W_OUT-1:0]  omin;
    logic [W_OUT-1:0]  omax;
    logic              lock;
  } cfg_t;

  localparam cfg_t CFG_RST = '{os: '0, sp: '0, kp: '0, ki: '0, kd: '0, src: '0,
                               init: '0, omin: '0, omax: '1, lock: 1'b0};

  typedef enum logic [2:0] {S_IDLE, S_CONVST, S_WAIT_HI, S_READ, S_WAIT_LO} state_t;

  cfg_t   shadow, active, snap;
  state_t state, nxt;
  logic [2:0]       rst_cnt;
  logic             cont_mode;
  logic [CNT_W-1:0] bit_cnt;
  logic [LINE_W-1:0] sh_a, sh_b;
  logic [N_CHAN-1:0][W_DATA-1:0] chans;
  logic             sample_go;
  logic [STAGES:0]  vld_pipe;

  // ---------------- register file ----------------
  always_ff @(posedge clk17_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      shadow <= CFG_RST;
    end else if (cfg_if.cfg_we_in) begin
      case (cfg_if.cfg_addr_in)
        8'h01: shadow.os   <= cfg_if.cfg_data_in[2:0];
        8'h04: shadow.sp   <= W_COEF'(cfg_if.cfg_data_in);
        8'h05: shadow.kp   <= W_COEF'(cfg_if.cfg_data_in);
        8'h06: shadow.ki   <= W_COEF'(cfg_if.cfg_data_in);
        8'h07: shadow.kd   <= W_COEF'(cfg_if.cfg_data_in);
        8'h09: shadow.src  <= cfg_if.cfg_data_in[2:0];
        8'h0d: shadow.init <= W_OUT'(cfg_if.cfg_data_in);
        8'h10: shadow.omin <= W_OUT'(cfg_if.cfg_data_in);
        8'h13: shadow.omax <= W_OUT'(cfg_if.cfg_data_in);
        8'h17: shadow.lock <= cfg_if.cfg_data_in[0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk17_in or negedge rst_n_in) begin
    if (!rst_n_in)             active <= CFG_RST;
    else if (module_update_in) active <= shadow;
  end

  assign adc_os_out = active.os;

  // ---------------- ADC reset / run mode ----------------
  // Counter saturates at 4 so the ADC sees exactly 4 reset clocks after release.
  always_ff @(posedge clk17_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rst_cnt   <= '0;
      cont_mode <= 1'b0;
    end else begin
      if (rst_cnt != 3'd4) rst_cnt <= rst_cnt + 3'd1;
      if (adc_cstart_in)   cont_mode <= 1'b1;
    end
  end

  assign adc_reset_out = (rst_cnt != 3'd4);

  // ---------------- ADC FSM ----------------
  always_ff @(posedge clk17_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= S_IDLE;
    else           state <= nxt;
  end

  always_comb begin
    nxt            = state;
    adc_convst_out = 1'b0;
    adc_n_cs_out   = 1'b1;
    case (state)
      S_IDLE:    if (cont_mode && !adc_reset_out) nxt = S_CONVST;
      S_CONVST:  begin adc_convst_out = 1'b1; nxt = S_WAIT_HI; end
      S_WAIT_HI: if (adc_busy_in) nxt = S_READ;
      S_READ:    begin adc_n_cs_out = 1'b0; if (bit_cnt == LAST) nxt = S_WAIT_LO; end
      S_WAIT_LO: if (!adc_busy_in) nxt = S_CONVST;
      default:   nxt = S_IDLE;
    endcase
  end

  // READ spans LINE_W+1 clocks: LINE_W shift cycles, then one cycle with the
  // clock parked high while the frame is latched. Gating on bit_cnt keeps the
  // pulse count at exactly LINE_W.
  assign adc_sclk_out = (state == S_READ && bit_cnt != LAST) ? clk17_in : 1'b1;
  assign sample_go    = (state == S_READ) && (bit_cnt == LAST);

  always_ff @(posedge clk17_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      bit_cnt <= '0;
      sh_a    <= '0;
      sh_b    <= '0;
    end else if (state != S_READ) begin
      bit_cnt <= '0;
    end else if (bit_cnt != LAST) begin
      bit_cnt <= bit_cnt + 1'b1;
      sh_a    <= {sh_a[LINE_W-2:0], adc_data_a_in};
      sh_b    <= {sh_b[LINE_W-2:0], adc_data_b_in};
    end
  end

  // First-shifted bits end up at the top: channel 0 is the MSB slice of line A.
  for (genvar c = 0; c < N_CHAN / 2; c++) begin : g_ch
    assign chans[c]            = sh_a[LINE_W-1-W_DATA*c -: W_DATA];
    assign chans[c+N_CHAN/2]   = sh_b[LINE_W-1-W_DATA*c -: W_DATA];
  end

  // ---------------- PID pipeline ----------------
  // The active config is snapshotted with the sample so a mid-pipeline update
  // only affects the following sample.
  logic signed [W_DATA-1:0] x_r;
  logic signed [W_ERR-1:0]  err, err_prev;
  logic signed [W_ERR:0]    de;
  logic signed [31:0]       integ, i_next;
  logic signed [32:0]       i_sum;
  logic signed [47:0]       p_term, i_term, d_term, y, y_min, y_max;
  logic signed [W_COEF-1:0] sp_s, kp_s, ki_s, kd_s;

  assign sp_s = snap.sp;
  assign kp_s = snap.kp;
  assign ki_s = snap.ki;
  assign kd_s = snap.kd;

  always_ff @(posedge clk17_in or negedge rst_n_in) begin
    if (!rst_n_in) vld_pipe <= '0;
    else           vld_pipe <= {vld_pipe[STAGES-1:0], sample_go};
  end

  always_ff @(posedge clk17_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      x_r  <= '0;
      snap <= CFG_RST;
    end else if (sample_go) begin
      x_r  <= chans[active.src];
      snap <= active;
    end
  end

  // stage 1: error
  always_ff @(posedge clk17_in or negedge rst_n_in) begin
    if (!rst_n_in)        err <= '0;
    else if (vld_pipe[0]) err <= W_ERR'(sp_s) - W_ERR'(x_r);
  end

  // stage 2: saturating integrator and products
  always_comb begin
    i_sum  = 33'(integ) + 33'(err);
    i_next = i_sum[31:0];
    if (i_sum[32] != i_sum[31]) i_next = i_sum[32] ? 32'sh8000_0000 : 32'sh7fff_ffff;
    de     = (W_ERR+1)'(err) - (W_ERR+1)'(err_prev);
  end

  always_ff @(posedge clk17_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      integ    <= '0;
      err_prev <= '0;
      p_term   <= '0;
      i_term   <= '0;
      d_term   <= '0;
    end else begin
      if (vld_pipe[1]) begin
        if (snap.lock) begin
          integ    <= i_next;
          err_prev <= err;
          p_term   <= 48'(kp_s) * 48'(err);
          i_term   <= 48'(ki_s) * 48'(i_next);
          d_term   <= 48'(kd_s) * 48'(de);
        end else begin
          integ    <= '0;
          err_prev <= '0;
          p_term   <= '0;
          i_term   <= '0;
          d_term   <= '0;
        end
      end
      if (pid_clear_in) begin   // wins over a same-cycle integrator update
        integ    <= '0;
        err_prev <= '0;
      end
    end
  end

  // stage 3: sum and clamp; an inverted window resolves to opp_min
  always_comb begin
    y     = 48'(snap.init) + p_term + i_term + d_term;
    y_min = 48'(snap.omin);
    y_max = 48'(snap.omax);
  end

  always_ff @(posedge clk17_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      out_data <= '0;
    end else if (vld_pipe[2]) begin
      if (snap.omin > snap.omax) out_data <= snap.omin;
      else if (y < y_min)        out_data <= snap.omin;
      else if (y > y_max)        out_data <= snap.omax;
      else                       out_data <= y[W_OUT-1:0];
    end
  end

  assign out_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_pid_controller_core.sv
module tb_pid_controller_core;
  logic        clk17_in = 1'b0;
  logic        rst_n_in = 1'b1;
  logic        module_update_in = 1'b0, adc_cstart_in = 1'b0, pid_clear_in = 1'b0;
  logic        adc_busy_in = 1'b0, adc_data_a_in = 1'b0, adc_data_b_in = 1'b0;
  logic [2:0]  adc_os_out;
  logic        adc_convst_out, adc_reset_out, adc_sclk_out, adc_n_cs_out;
  logic [15:0] out_data;
  logic        out_valid;

  pid_controller_core_if cfg_bus ();

  pid_controller_core dut (
    .clk17_in(clk17_in), .rst_n_in(rst_n_in), .cfg_if(cfg_bus),
    .module_update_in(module_update_in), .adc_cstart_in(adc_cstart_in),
    .pid_clear_in(pid_clear_in), .adc_busy_in(adc_busy_in),
    .adc_data_a_in(adc_data_a_in), .adc_data_b_in(adc_data_b_in),
    .adc_os_out(adc_os_out), .adc_convst_out(adc_convst_out),
    .adc_reset_out(adc_reset_out), .adc_sclk_out(adc_sclk_out),
    .adc_n_cs_out(adc_n_cs_out), .out_data(out_data), .out_valid(out_valid)
  );

  always #5 clk17_in = ~clk17_in;

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- ADC model ----------------
  logic [17:0] ch [8];

  always begin
    logic [71:0] sa, sb;
    @(negedge clk17_in iff adc_convst_out);
    repeat (2) @(negedge clk17_in);
    adc_busy_in = 1'b1;
    sa = {ch[0], ch[1], ch[2], ch[3]};
    sb = {ch[4], ch[5], ch[6], ch[7]};
    @(negedge adc_n_cs_out);
    for (int i = 0; i < 72; i++) begin
      @(negedge clk17_in);
      adc_data_a_in = sa[71-i];
      adc_data_b_in = sb[71-i];
    end
    @(posedge adc_n_cs_out);
    @(negedge clk17_in);
    adc_busy_in = 1'b0;
  end

  // ---------------- monitors ----------------
  int cyc = 0, ncs_low = 0, nvalid = 0, nconv = 0, nsclk = 0, t_end = 0, t_valid = 0;
  logic ncs_prev = 1'b1;

  always @(posedge clk17_in) begin
    #1;
    cyc++;
    if (!adc_n_cs_out) ncs_low++;
    if (adc_n_cs_out && !ncs_prev) t_end = cyc;
    ncs_prev = adc_n_cs_out;
    if (out_valid) begin nvalid++; t_valid = cyc; end
    if (adc_convst_out) nconv++;
  end

  always @(negedge adc_sclk_out) nsclk++;

  // ---------------- drivers ----------------
  task automatic wr(input logic [7:0] a, input logic [15:0] d);
    @(negedge clk17_in);
    cfg_bus.cfg_we_in = 1'b1; cfg_bus.cfg_addr_in = a; cfg_bus.cfg_data_in = d;
    @(negedge clk17_in);
    cfg_bus.cfg_we_in = 1'b0;
  endtask

  task automatic upd();
    @(negedge clk17_in); module_update_in = 1'b1;
    @(negedge clk17_in); module_update_in = 1'b0;
  endtask

  task automatic clr();
    @(negedge clk17_in); pid_clear_in = 1'b1;
    @(negedge clk17_in); pid_clear_in = 1'b0;
  endtask

  int b_sclk = 0, b_ncs = 0, b_valid = 0;

  task automatic sample(input string tag, input logic [15:0] exp, input bit conv);
    int k = 0;
    while (k < 400) begin
      @(negedge clk17_in);
      k++;
      if (out_valid) break;
    end
    chk({tag, " valid"}, out_valid, 1);
    chk(tag, out_data, exp);
    if (conv) begin
      chk({tag, " sclk pulses"}, nsclk - b_sclk, 72);
      chk({tag, " ncs low clocks"}, ncs_low - b_ncs, 73);
      chk({tag, " valid count"}, nvalid - b_valid, 1);
      chk({tag, " latency"}, t_valid - t_end, 3);
    end
    b_sclk = nsclk; b_ncs = ncs_low; b_valid = nvalid;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    cfg_bus.cfg_we_in = 1'b0; cfg_bus.cfg_addr_in = '0; cfg_bus.cfg_data_in = '0;
    for (int i = 0; i < 8; i++) ch[i] = '0;
    ch[0] = 18'd1111; ch[3] = 18'd4444; ch[4] = 18'd777; ch[1] = 18'h3ffff; ch[7] = 18'h2aaaa;

    // reset state
    #1 rst_n_in = 1'b0;
    repeat (3) @(negedge clk17_in);
    chk("rst convst", adc_convst_out, 0);
    chk("rst n_cs", adc_n_cs_out, 1);
    chk("rst sclk", adc_sclk_out, 1);
    chk("rst out_data", out_data, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst os", adc_os_out, 0);
    chk("rst adc_reset", adc_reset_out, 1);
    rst_n_in = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk17_in); #1;
      chk($sformatf("adc_reset clk%0d", i), adc_reset_out, (i < 4) ? 1 : 0);
    end
    repeat (10) @(negedge clk17_in);
    chk("no convst before cstart", nconv, 0);

    // shadow vs active
    wr(8'h01, 16'h0005);
    chk("os before update", adc_os_out, 0);
    upd();
    chk("os after update", adc_os_out, 5);

    // pass-through config (kp=-1, sp=0 -> y = x) to observe the latched channel
    wr(8'h04, 16'd0); wr(8'h05, 16'hffff); wr(8'h06, 16'd0); wr(8'h07, 16'd0);
    wr(8'h0d, 16'd0); wr(8'h09, 16'd0); wr(8'h17, 16'd1);
    upd();
    b_sclk = nsclk; b_ncs = ncs_low; b_valid = nvalid;
    @(negedge clk17_in); adc_cstart_in = 1'b1;
    @(negedge clk17_in); adc_cstart_in = 1'b0;
    sample("src0", 16'd1111, 1'b1);
    wr(8'h09, 16'd3); upd();
    sample("src3", 16'd4444, 1'b1);
    wr(8'h09, 16'd4); upd();
    sample("src4 line B", 16'd777, 1'b1);
    @(negedge clk17_in); adc_cstart_in = 1'b1;   // restart while running: no effect
    @(negedge clk17_in); adc_cstart_in = 1'b0;
    sample("src4 after cstart", 16'd777, 1'b1);

    // lock off
    wr(8'h09, 16'd0); wr(8'h0d, 16'd500); wr(8'h10, 16'd0); wr(8'h13, 16'hffff);
    wr(8'h17, 16'd0); upd();
    sample("lock off a", 16'd500, 1'b1);
    sample("lock off b", 16'd500, 1'b1);

    // lock on, PI accumulation
    wr(8'h04, 16'd1200); wr(8'h05, 16'd10); wr(8'h06, 16'd3); wr(8'h07, 16'd0);
    wr(8'h17, 16'd1); upd();
    sample("pi 1", 16'd1657, 1'b0);
    sample("pi 2", 16'd1924, 1'b0);
    sample("pi 3", 16'd2191, 1'b1);
    clr();
    sample("pi after clear", 16'd1657, 1'b0);

    // negative y clamps to min
    wr(8'h04, 16'd3); upd(); clr();
    sample("clamp low", 16'd0, 1'b0);

    // large positive error clamps to max
    wr(8'h04, 16'h7fff); wr(8'h13, 16'd1000); upd(); clr();
    sample("clamp high", 16'd1000, 1'b0);

    // inverted window resolves to min
    wr(8'h10, 16'd2000); upd();
    sample("min gt max", 16'd2000, 1'b0);

    // derivative only
    wr(8'h04, 16'd1200); wr(8'h05, 16'd0); wr(8'h06, 16'd0); wr(8'h07, 16'd2);
    wr(8'h10, 16'd0); wr(8'h13, 16'hffff); upd(); clr();
    sample("kd step", 16'd678, 1'b0);
    sample("kd steady", 16'd500, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pid_controller_core.md
Name: pid_controller_core

Overview:
Single-clock PID lock loop for one channel. Drives an AD7606-style 8-channel, 18-bit ADC over a dual-line serial interface and selects one channel as the process variable. Runs a signed PID on that channel and passes the result through an output stage with init offset and min/max clamp. Sits between the host-config decode (register writes plus update/trigger pulses) and the DAC/DDS serializers.

Parameters:
W_DATA, 18, ADC sample width (signed two's complement)
N_CHAN, 8, ADC channels; 4 per serial line (A: ch0-3, B: ch4-7)
W_COEF, 16, signed P/I/D coefficient and setpoint-register width
W_OUT, 16, unsigned output word width

Ports:
clk17_in  in  1  system/ADC clock; all logic on rising edge
rst_n_in  in  1  asynchronous active-low reset
cfg_we_in  in  1  shadow-register write strobe
cfg_addr_in  in  8  register address
cfg_data_in  in  16  register write data
module_update_in  in  1  1-cycle pulse: copy all shadow registers to active registers
adc_cstart_in  in  1  1-cycle pulse: start continuous conversions
pid_clear_in  in  1  1-cycle pulse: clear integrator and previous error
adc_busy_in  in  1  ADC BUSY
adc_data_a_in  in  1  ADC DOUTA
adc_data_b_in  in  1  ADC DOUTB
adc_os_out  out  3  oversampling select
adc_convst_out  out  1  conversion start
adc_reset_out  out  1  ADC reset
adc_sclk_out  out  1  ADC serial clock
adc_n_cs_out  out  1  ADC chip select, active low
out_data  out  W_OUT  clamped controller output
out_valid  out  1  1-cycle strobe when out_data updates

Behaviour:
- Reset, asynchronous: all registers 0, convst 0, n_cs 1, sclk 1, out_data 0, out_valid 0, continuous mode off.
- adc_reset_out is high for the first 4 clocks after rst_n_in deasserts, then low.
- Register map. Shadow written when cfg_we_in is high. Active value changes only on module_update_in.
  - 0x01 adc_os[2:0]
  - 0x04 setpoint (signed, sign-extended to 18 bits)
  - 0x05 kp, 0x06 ki, 0x07 kd (signed)
  - 0x09 src_sel[2:0]
  - 0x0d opp_init
  - 0x10 opp_min (reset 0)
  - 0x13 opp_max (reset 0xFFFF)
  - 0x17 lock_en[0]
  - Other addresses are ignored.
- adc_os_out always equals active adc_os.
- ADC FSM: IDLE -> CONVST -> WAIT_BUSY_HI -> READ -> WAIT_BUSY_LO -> CONVST.
  - adc_cstart_in sets continuous mode; mode clears only on reset.
  - IDLE: leave when continuous mode is set and adc_reset_out is low.
  - CONVST: adc_convst_out high for exactly 1 clock.
  - WAIT_BUSY_HI: wait for adc_busy_in=1.
  - READ: n_cs low for 73 clocks (edge k to k+73). adc_sclk_out = clk17_in gated while n_cs is low. Sample both lines on rising edges k+1..k+72, MSB first. Bits 18c..18c+17 of the line A stream form channel c; line B stream maps to channel c+4.
  - After READ: latch channel src_sel, go to WAIT_BUSY_LO.
  - WAIT_BUSY_LO: wait for adc_busy_in=0, then go to CONVST.
  - adc_cstart_in while already running has no effect.
- PID pipeline: fixed 3-clock latency from the READ-end latch to out_valid.
  - Stage 1: e = setpoint - x (19-bit signed).
  - Stage 2: if lock_en, I = sat32(I + e). Products kp*e, ki*I, kd*(e - e_prev); then e_prev = e.
  - Stage 3: y = opp_init + kp*e + ki*I + kd*de, 48-bit signed. out_data = clamp(y, opp_min, opp_max). out_valid pulses.
- Lock disabled: I and e_prev held at 0; out_data = clamp(opp_init).
- Integrator saturates at +(2^31-1) and -2^31; it never wraps.
- pid_clear_in zeroes I and e_prev. It takes precedence over a same-cycle update.
- If opp_min > opp_max, output = opp_min.
- module_update_in mid-pipeline: new coefficients apply from the next sample.
- adc_busy_in never rising leaves the FSM in WAIT_BUSY_HI indefinitely; there is no timeout.

Test Plan:
- Reset then 4 clocks -> all outputs at reset values; adc_reset_out high for 4 clocks then low; no convst before adc_cstart_in.
- Write os=0x5 without update, then pulse module_update_in -> adc_os_out changes only after the update pulse, to 5.
- cstart, busy high after convst, streams with ch0=1111, ch3=4444 (line A) -> exactly 72 sclk pulses, n_cs low 73 clocks, src_sel=0 latches 1111, src_sel=3 latches 4444.
- Lock off, opp_init=500, min=0, max=65535 -> out_data=500 every sample, out_valid once per conversion, 3 clocks after read end.
- Lock on, setpoint=1200, kp=10, ki=3, kd=0, init=500, x=1111 repeated -> outputs 1657, 1924, 2191; pid_clear_in then one more sample -> 1657.
- setpoint=3, kp=10, ki=3, x=1111, min=0 -> y=-13904 clamps to 0; with max=1000 and large positive error -> output 1000.
